// File: rtl/level1b_pkg.sv
// Shared definitions for the level1b remap/clock-select controller: register map,
// control-bit positions, window register layouts and the clock FSM state encoding.
package level1b_pkg;

    localparam int unsigned ADR_W  = 16;
    localparam int unsigned BANK_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PAGE_W = 4;
    localparam int unsigned TGT_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [7:0] OFF_MAP_CTL   = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h01;
    localparam logic [7:0] OFF_GPIO_DIR  = 8'h02;
    localparam logic [7:0] OFF_GPIO_DATA = 8'h03;
    localparam logic [7:0] OFF_WIN_BASE  = 8'h10;

    localparam int unsigned MAP_HS_EN_BIT   = 6;
    localparam int unsigned MAP_CLK_DIV_LSB = 0;
    localparam int unsigned WIN_EN_BIT      = 7;
    localparam int unsigned WIN_WT_BIT      = 6;

    typedef enum logic [1:0] {
        ST_LS    = 2'd0,
        ST_ARM   = 2'd1,
        ST_HS    = 2'd2,
        ST_DRAIN = 2'd3
    } fsm_state_t;

    typedef struct packed {
        logic [PAGE_W-1:0] base;
        logic [PAGE_W-1:0] limit;
    } win_range_t;

    typedef struct packed {
        logic             en;
        logic             wt;
        logic [2:0]       rsvd;
        logic [TGT_W-1:0] tgt;
    } win_ctl_t;

    function automatic logic [7:0] win_range_off(input int unsigned w);
        return 8'(OFF_WIN_BASE + 8'(2 * w));
    endfunction

    function automatic logic [7:0] win_ctl_off(input int unsigned w);
        return 8'(OFF_WIN_BASE + 8'(2 * w + 1));
    endfunction

endpackage

// File: rtl/level1b_remap_win.sv
// One remap window: range/control registers and the page hit comparator.
module level1b_remap_win
    import level1b_pkg::*;
(
    input  logic              cpu_phi2,
    input  logic              resetb,
    input  logic              range_wr,
    input  logic              ctl_wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PAGE_W-1:0] page,
    input  logic              qual,
    input  logic              is_write,
    output logic              hit_c,
    output win_range_t        range_q,
    output win_ctl_t          ctl_q
);

    always_ff @(negedge cpu_phi2 or negedge resetb) begin
        if (!resetb) begin
            range_q <= '0;
            ctl_q   <= '0;
        end else begin
            if (range_wr) begin
                range_q <= win_range_t'(wdata);
            end
            if (ctl_wr) begin
                ctl_q.en   <= wdata[WIN_EN_BIT];
                ctl_q.wt   <= wdata[WIN_WT_BIT];
                ctl_q.rsvd <= '0;
                ctl_q.tgt  <= wdata[TGT_W-1:0];
            end
        end
    end

    // base>limit naturally never hits; write-through windows pass writes to bank 0
    assign hit_c = qual && ctl_q.en
                && (range_q.base <= page) && (page <= range_q.limit)
                && !(ctl_q.wt && is_write);

endmodule

// File: rtl/level1b_remap_ctrl.sv
// Bank-0 remap windows, paged-ROM shadow, register file and HS clock arbitration
// for the 65816 BBC accelerator. Optional GPIO registers with `L1B_GPIO_EN.
module level1b_remap_ctrl
    import level1b_pkg::*;
#(
    parameter int unsigned NUM_WIN      = 4,
    parameter int unsigned SYNC_THRESH  = 2,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned PAGEREG_W    = 8,
    parameter logic [15:0] PAGEREG_ADR  = 16'hFE30,
    parameter logic [4:0]  TGT_BANK_HI  = 5'h1F
`ifdef L1B_GPIO_EN
    ,
    parameter int unsigned GPIO_SZ      = 6
`endif
) (
    input  logic                 cpu_phi2,
    input  logic                 resetb,
    input  logic [ADR_W-1:0]     cpu_adr,
    input  logic [BANK_W-1:0]    cpu_bank,
    input  logic                 cpu_vda,
    input  logic                 cpu_vpa,
    input  logic                 cpu_rnw,
    input  logic [DATA_W-1:0]    cpu_wdata,
    input  logic                 hs_ready,
    input  logic                 ls_ready,
    output logic [BANK_W-1:0]    eff_bank,
    output logic                 reg_rd_en,
    output logic [DATA_W-1:0]    reg_rdata,
    output logic                 hs_sel,
    output logic                 dummy_access,
    output logic [PAGEREG_W-1:0] bbc_pagereg
`ifdef L1B_GPIO_EN
    ,
    input  logic [GPIO_SZ-1:0]   gpio_in,
    output logic [GPIO_SZ-1:0]   gpio_out,
    output logic [GPIO_SZ-1:0]   gpio_oe
`endif
);

    logic              valid_c, sync_c, reg_cyc_c, reg_wr_c, map_wr_c, himem_c;
    logic [7:0]        off_c;
    logic [PAGE_W-1:0] page_c;

    assign valid_c   = cpu_vda | cpu_vpa;
    assign sync_c    = cpu_vda & cpu_vpa;
    assign reg_cyc_c = cpu_vda && (cpu_bank[7:6] == 2'b10);
    assign reg_wr_c  = reg_cyc_c && !cpu_rnw;
    assign off_c     = cpu_adr[7:0];
    assign page_c    = cpu_adr[ADR_W-1:ADR_W-PAGE_W];
    assign map_wr_c  = reg_wr_c && (off_c == OFF_MAP_CTL);

    logic       hs_en_q;
    logic [1:0] clk_div_q;

    always_ff @(negedge cpu_phi2 or negedge resetb) begin
        if (!resetb) begin
            hs_en_q   <= 1'b0;
            clk_div_q <= 2'b00;
        end else if (map_wr_c) begin
            hs_en_q   <= cpu_wdata[MAP_HS_EN_BIT];
            clk_div_q <= cpu_wdata[MAP_CLK_DIV_LSB +: 2];
        end
    end

    logic [NUM_WIN-1:0] win_hit_c;
    win_range_t         win_range_q [NUM_WIN];
    win_ctl_t           win_ctl_q   [NUM_WIN];

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        level1b_remap_win u_win (
            .cpu_phi2 (cpu_phi2),
            .resetb   (resetb),
            .range_wr (reg_wr_c && (off_c == win_range_off(w))),
            .ctl_wr   (reg_wr_c && (off_c == win_ctl_off(w))),
            .wdata    (cpu_wdata),
            .page     (page_c),
            .qual     (valid_c && (cpu_bank == 8'h00)),
            .is_write (!cpu_rnw),
            .hit_c    (win_hit_c[w]),
            .range_q  (win_range_q[w]),
            .ctl_q    (win_ctl_q[w])
        );
    end

    // lowest-index window wins on overlap
    logic             hit_any_c;
    logic [TGT_W-1:0] hit_tgt_c;

    always_comb begin
        hit_any_c = 1'b0;
        hit_tgt_c = '0;
        for (int unsigned w = 0; w < NUM_WIN; w++) begin
            if (win_hit_c[w] && !hit_any_c) begin
                hit_any_c = 1'b1;
                hit_tgt_c = win_ctl_q[w].tgt;
            end
        end
    end

    assign eff_bank = hit_any_c ? {TGT_BANK_HI, hit_tgt_c} : cpu_bank;
    assign himem_c  = eff_bank[7];

    always_ff @(negedge cpu_phi2 or negedge resetb) begin
        if (!resetb) begin
            bbc_pagereg <= '0;
        end else if (cpu_vda && !cpu_rnw && (cpu_bank == 8'h00) && (cpu_adr == PAGEREG_ADR)) begin
            bbc_pagereg <= cpu_wdata[PAGEREG_W-1:0];
        end
    end

`ifdef L1B_GPIO_EN
    logic [GPIO_SZ-1:0] gpio_dir_q, gpio_data_q;

    always_ff @(negedge cpu_phi2 or negedge resetb) begin
        if (!resetb) begin
            gpio_dir_q  <= '0;
            gpio_data_q <= '0;
        end else if (reg_wr_c) begin
            if (off_c == OFF_GPIO_DIR)  gpio_dir_q  <= cpu_wdata[GPIO_SZ-1:0];
            if (off_c == OFF_GPIO_DATA) gpio_data_q <= cpu_wdata[GPIO_SZ-1:0];
        end
    end

    assign gpio_out = gpio_data_q;
    assign gpio_oe  = gpio_dir_q;
`endif

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d, sync_inc_c;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             leave_hs_c;

    assign sync_inc_c = (sync_cnt_q == '1) ? sync_cnt_q : sync_cnt_q + CNT_W'(1);
    assign leave_hs_c = (valid_c && !himem_c) || !hs_en_q;

    always_ff @(negedge cpu_phi2 or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_LS;
            sync_cnt_q  <= '0;
            drain_cnt_q <= '0;
            hs_sel      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            hs_sel      <= (state_d == ST_ARM) || (state_d == ST_HS);
        end
    end

    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_LS: begin
                // clearing hs_en in the same cycle overrides any arming progress
                if (map_wr_c && !cpu_wdata[MAP_HS_EN_BIT]) begin
                    sync_cnt_d = '0;
                end else if (sync_c) begin
                    if (!himem_c) begin
                        sync_cnt_d = '0;
                    end else if (hs_en_q) begin
                        if (32'(sync_inc_c) >= SYNC_THRESH) begin
                            state_d    = ST_ARM;
                            sync_cnt_d = '0;
                        end else begin
                            sync_cnt_d = sync_inc_c;
                        end
                    end
                end
            end
            ST_ARM: begin
                if (leave_hs_c) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
                end else if (hs_ready) begin
                    state_d = ST_HS;
                end
            end
            ST_HS: begin
                if (leave_hs_c) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end else if (ls_ready) begin
                    state_d = ST_LS;
                end
            end
            default: state_d = ST_LS;
        endcase
    end

    assign dummy_access = (state_q != ST_LS) || himem_c;
    assign reg_rd_en    = reg_cyc_c && cpu_rnw;

    always_comb begin
        reg_rdata = '0;
        for (int unsigned w = 0; w < NUM_WIN; w++) begin
            if (off_c == win_range_off(w)) reg_rdata = win_range_q[w];
            if (off_c == win_ctl_off(w))   reg_rdata = win_ctl_q[w];
        end
        case (off_c)
            OFF_MAP_CTL: begin
                reg_rdata[MAP_HS_EN_BIT]           = hs_en_q;
                reg_rdata[MAP_CLK_DIV_LSB +: 2]    = clk_div_q;
            end
            OFF_STATUS:    reg_rdata = {sync_cnt_q, 2'b00, state_q};
`ifdef L1B_GPIO_EN
            OFF_GPIO_DIR:  reg_rdata = 8'(gpio_dir_q);
            OFF_GPIO_DATA: reg_rdata = 8'(gpio_in);
`endif
            default: ;
        endcase
    end

endmodule
